ring_decoder: RTL and testbench



---
 rtl/ring_pkg.sv | 23 ++
 rtl/ring_onehot_enc.sv | 21 ++
 rtl/ring_decoder.sv | 109 ++++++++++
 tb/tb_ring_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring decoder.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } ring_state_t;

  // Widest ring the helpers accept; narrower codes are zero-extended.
  localparam int MAX_N = 32;
  localparam int IDX_W = $clog2(3);

  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
  endfunction

  // Index expected after idx: the ring rotates downward and wraps to n-1.
  function automatic int next_idx(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary encoder for an N-bit ring code.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     code,
  output logic             onehot_ok,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    index     = '0;
    onehot_ok = is_onehot(MAX_N'(code));
    for (int k = 0; k < N; k++) begin
      if (code[k]) index = IDX_W'(k);
    end
  end

endmodule

// File: rtl/ring_decoder.sv
// Ring-code decoder: locks onto the rotation order and counts errors once locked.
// Optional macro RING_DEC_PREDICT_EN adds the registered ring_fix prediction output.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int N        = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           ring_in,
  output logic [$clog2(N)-1:0]   idx,
  output logic                   valid,
  output logic                   locked,
  output logic                   err_pulse,
`ifdef RING_DEC_PREDICT_EN
  output logic [N-1:0]           ring_fix,
`endif
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int DW    = $clog2(N);
  localparam int SEQ_W = $clog2(LOCK_CNT + 1);

  ring_state_t    state;
  logic [DW-1:0]  prev_idx;
  logic [SEQ_W-1:0] seq_cnt;

  logic           onehot_ok;
  logic [DW-1:0]  enc_idx;
  logic [DW-1:0]  exp_idx;
  logic           correct;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  ring_onehot_enc #(.N(N), .IDX_W(DW)) u_enc (
    .code      (ring_in),
    .onehot_ok (onehot_ok),
    .index     (enc_idx)
  );

  assign exp_idx = DW'(next_idx(int'(prev_idx), N));
  assign correct = onehot_ok && (enc_idx == exp_idx);
  assign locked  = (state == LOCKED);

  // Sample stage: every output is registered from the code taken at this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      idx       <= '0;
      valid     <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      prev_idx  <= '0;
      seq_cnt   <= '0;
    end else begin
      valid     <= onehot_ok;
      err_pulse <= 1'b0;
      if (onehot_ok) begin
        idx      <= enc_idx;
        prev_idx <= enc_idx;
      end
      case (state)
        HUNT: begin
          if (onehot_ok) begin
            state   <= SYNC;
            seq_cnt <= '0;
          end
        end
        SYNC: begin
          if (correct) begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
            if (seq_cnt + SEQ_W'(1) == SEQ_W'(LOCK_CNT)) state <= LOCKED;
          end else if (onehot_ok) begin
            seq_cnt <= '0;
          end else begin
            state <= HUNT;
          end
        end
        LOCKED: begin
          if (!correct) begin
            err_pulse <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            seq_cnt   <= '0;
            state     <= onehot_ok ? SYNC : HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef RING_DEC_PREDICT_EN
  // Error edges only occur from LOCKED, so the current state covers both cases
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_fix <= '0;
    end else if (state == LOCKED) begin
      ring_fix <= N'(1) << exp_idx;
    end else begin
      ring_fix <= ring_in;
    end
  end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Randomized self-checking bench for ring_decoder with a behavioural reference model.
module tb_ring_decoder;
  localparam int N        = 3;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 2;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;
  localparam int IW       = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     ring_in;
  logic [IW-1:0]    idx;
  logic             valid, locked, err_pulse;
  logic [ERR_W-1:0] err_cnt;
`ifdef RING_DEC_PREDICT_EN
  logic [N-1:0]     ring_fix;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ring_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in),
    .idx       (idx),
    .valid     (valid),
    .locked    (locked),
    .err_pulse (err_pulse),
`ifdef RING_DEC_PREDICT_EN
    .ring_fix  (ring_fix),
`endif
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = hunting, 1 = syncing, 2 = locked
  bit           m_init = 0;
  int           m_mode, m_run, m_prev, m_idx, m_errs;
  bit           m_valid, m_pulse;
  logic [N-1:0] m_fix;

  always begin
    @(posedge clk);
    if (rst === 1'b1) begin
      m_init = 1; m_mode = 0; m_run = 0; m_prev = 0; m_idx = 0;
      m_errs = 0; m_valid = 0; m_pulse = 0; m_fix = '0;
    end else if (m_init) begin
      int  pos;
      bit  oh, good;
      int  want;
      pos = -1;
      for (int k = 0; k < N; k++) if (ring_in[k]) pos = k;
      oh   = ($countones(ring_in) == 1);
      want = (m_prev + N - 1) % N;
      good = oh && (pos == want);
      m_fix   = (m_mode == 2) ? N'(1 << want) : ring_in;
      m_pulse = (m_mode == 2) && !good;
      if (m_pulse && m_errs < ERR_MAX) m_errs++;
      if (m_mode == 0) begin
        if (oh) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        if (good) begin
          m_run++;
          if (m_run == LOCK_CNT) m_mode = 2;
        end else if (oh) m_run = 0;
        else m_mode = 0;
      end else if (!good) begin
        m_mode = oh ? 1 : 0;
        m_run  = 0;
      end
      m_valid = oh;
      if (oh) begin m_idx = pos; m_prev = pos; end
    end
    #1;
    if (m_init) begin
      chk("model_idx",    int'(idx),       m_idx);
      chk("model_valid",  int'(valid),     int'(m_valid));
      chk("model_locked", int'(locked),    int'(m_mode == 2));
      chk("model_pulse",  int'(err_pulse), int'(m_pulse));
      chk("model_errcnt", int'(err_cnt),   m_errs);
`ifdef RING_DEC_PREDICT_EN
      chk("model_fix",    int'(ring_fix),  int'(m_fix));
`endif
    end
  end

  task automatic step(input logic [N-1:0] v, input logic r);
    @(negedge clk);
    ring_in = v;
    rst     = r;
    @(posedge clk);
    #2;
  endtask

  task automatic relock();
    step(3'b100, 1'b0);
    step(3'b010, 1'b0);
    step(3'b001, 1'b0);
  endtask

  initial begin
    int gen;
    ring_in = '0;
    rst     = 1'b1;
    step('0, 1'b1);
    step('0, 1'b1);
    chk("rst_idx", int'(idx), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_errcnt", int'(err_cnt), 0);

    // Lock-up: idx 2,1,0,2 and lock after the third sample
    step(3'b100, 1'b0); chk("lock_idx0", int'(idx), 2); chk("lock_l0", int'(locked), 0);
    step(3'b010, 1'b0); chk("lock_idx1", int'(idx), 1); chk("lock_l1", int'(locked), 0);
    step(3'b001, 1'b0); chk("lock_idx2", int'(idx), 0); chk("lock_l2", int'(locked), 1);
    step(3'b100, 1'b0); chk("lock_idx3", int'(idx), 2); chk("lock_err", int'(err_cnt), 0);

    // Invalid code while locked, then relock
    step(3'b110, 1'b0);
    chk("inv_valid", int'(valid), 0);
    chk("inv_pulse", int'(err_pulse), 1);
    chk("inv_cnt", int'(err_cnt), 1);
    chk("inv_locked", int'(locked), 0);
    chk("inv_idx_hold", int'(idx), 2);
    step(3'b010, 1'b0); chk("inv_pulse_once", int'(err_pulse), 0);
    step(3'b001, 1'b0);
    step(3'b100, 1'b0); chk("inv_relock", int'(locked), 1);

    // Order error while locked
    step(3'b010, 1'b0);
    step(3'b100, 1'b0);
    chk("ord_pulse", int'(err_pulse), 1);
    chk("ord_cnt", int'(err_cnt), 2);
    chk("ord_locked", int'(locked), 0);
    step(3'b010, 1'b0); chk("ord_sync", int'(locked), 0);
    step(3'b001, 1'b0); chk("ord_relock", int'(locked), 1);

    // Reset mid-operation with err_cnt=2
    step(3'b100, 1'b1);
    chk("mrst_idx", int'(idx), 0);
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_cnt", int'(err_cnt), 0);
    chk("mrst_valid", int'(valid), 0);
    relock();
    chk("mrst_relock", int'(locked), 1);

    // Saturation: five lock/error cycles with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 1'b0);
      chk("sat_pulse", int'(err_pulse), 1);
      chk("sat_cnt", int'(err_cnt), (i + 1 > ERR_MAX) ? ERR_MAX : i + 1);
      relock();
      chk("sat_relock", int'(locked), 1);
    end

    // Locked at idx 1, then a zero sample
    step(3'b100, 1'b0);
    step(3'b010, 1'b0);
    chk("pred_pre", int'(idx), 1);
    step(3'b000, 1'b0);
    chk("pred_pulse", int'(err_pulse), 1);
`ifdef RING_DEC_PREDICT_EN
    chk("pred_fix", int'(ring_fix), 1);
`endif

    // Randomized phase: mostly well-formed rotation with corruption and resets
    gen = 2;
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(N'($urandom_range(0, (1 << N) - 1)), 1'b1);
      end else if (r < 14) begin
        step(N'($urandom_range(0, (1 << N) - 1)), 1'b0);
      end else begin
        step(N'(1 << gen), 1'b0);
        gen = (gen + N - 1) % N;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
